// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared definitions for the MIPS multiply/divide unit.
//   op_e     : MULT/MULTU/DIV/DIVU encodings as presented on the op port
//   state_e  : sequencer states (IDLE, CALC, FIX)
//   LAST_ITER: counter value of the final CALC iteration (32 iterations, 0..31)
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam int LAST_ITER = 31;

  // op[1] selects divide, op[0] selects the unsigned flavour.
  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_twos_negate_64bit.sv
// twos_negate_64bit: conditional two's-complement negation.
//   neg  : 1 -> dout = -din, 0 -> dout = din
//   din  : 64-bit value
//   dout : 64-bit result
module twos_negate_64bit (
  input  logic        neg,
  input  logic [63:0] din,
  output logic [63:0] dout
);

  assign dout = neg ? (~din + 64'd1) : din;

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start, op           : launch an operation (sampled only while busy=0)
//   operand_a/operand_b : rs data and ALU-source mux output, needed only in
//                         the start cycle
//   hi_we, lo_we, wdata : MTHI/MTLO writes, honoured only when idle and no start
//   busy, done          : busy in CALC/FIX; done pulses the cycle after HI/LO update
//   div_zero            : last divide had a zero divisor, held until next start
//   hi, lo              : architectural HI/LO registers
//
// Handshake: start is accepted on any rising edge where busy=0 (including the
// done cycle); while busy=1 start and MTHI/MTLO are ignored. One bit per clock:
// 32 CALC cycles, then one FIX cycle that sign-corrects and writes HI/LO.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  op_e                  op_q;
  logic                 sign_a_q, sign_b_q, dz_q;
  logic [WIDTH-1:0]     opa_q, opb_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q, div_zero_q;

  op_e                  op_in;
  logic                 sign_a_in, sign_b_in, divz_in;
  logic [2*WIDTH-1:0]   abs_a, abs_b, fix_main, fix_rem;

  assign op_in     = op_e'(op);
  assign sign_a_in = op_is_signed(op_in) & operand_a[WIDTH-1];
  assign sign_b_in = op_is_signed(op_in) & operand_b[WIDTH-1];
  assign divz_in   = op_is_div(op_in) && (operand_b == '0);

  // Magnitudes of the incoming operands (low half used).
  twos_negate_64bit u_abs_a (.neg(sign_a_in), .din({{WIDTH{1'b0}}, operand_a}), .dout(abs_a));
  twos_negate_64bit u_abs_b (.neg(sign_b_in), .din({{WIDTH{1'b0}}, operand_b}), .dout(abs_b));

  // FIX correction: full product for multiplies, quotient for divides;
  // the remainder follows the dividend's sign on its own negator.
  twos_negate_64bit u_fix_main (
    .neg (sign_a_q ^ sign_b_q),
    .din (op_is_div(op_q) ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q),
    .dout(fix_main)
  );
  twos_negate_64bit u_fix_rem (
    .neg (sign_a_q),
    .din ({{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH]}),
    .dout(fix_rem)
  );

  // Upper halves of 32-bit negations carry no information.
  logic unused_upper;
  assign unused_upper = ^{abs_a[2*WIDTH-1:WIDTH], abs_b[2*WIDTH-1:WIDTH],
                          fix_rem[2*WIDTH-1:WIDTH]};

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the 65-bit {carry, acc} right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}. Shift the next
  // dividend bit into a 33-bit trial remainder and restore on borrow.
  logic [WIDTH:0]       rem_shift, rem_diff;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   div_next;
  assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_diff  = rem_shift - {1'b0, opb_q};
  assign q_bit     = ~rem_diff[WIDTH];
  assign rem_new   = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign div_next  = {rem_new, acc_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = divz_in ? S_FIX : S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(LAST_ITER)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_q       <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q       <= op_in;
            sign_a_q   <= sign_a_in;
            sign_b_q   <= sign_b_in;
            dz_q       <= divz_in;
            opa_q      <= abs_a[WIDTH-1:0];
            opb_q      <= abs_b[WIDTH-1:0];
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            // Divide by zero skips CALC: stage the raw dividend and the
            // all-ones quotient so FIX only has to copy them out.
            if (divz_in)                acc_q <= {operand_a, {WIDTH{1'b1}}};
            else if (op_is_div(op_in))  acc_q <= {{WIDTH{1'b0}}, abs_a[WIDTH-1:0]};
            else                        acc_q <= '0;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_is_div(op_q)) begin
            acc_q <= div_next;
          end else begin
            acc_q <= mul_next;
            opb_q <= opb_q >> 1;
          end
        end
        S_FIX: begin
          done_q <= 1'b1;
          if (dz_q) begin
            hi_q       <= acc_q[2*WIDTH-1:WIDTH];
            lo_q       <= acc_q[WIDTH-1:0];
            div_zero_q <= 1'b1;
          end else if (op_is_div(op_q)) begin
            hi_q <= fix_rem[WIDTH-1:0];
            lo_q <= fix_main[WIDTH-1:0];
          end else begin
            hi_q <= fix_main[2*WIDTH-1:WIDTH];
            lo_q <= fix_main[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
